// File: rtl/debug_observer_pkg.sv
// Shared types and constants for the CPU debug observer.
// Channel indices name the default channel layout of ch_data_i plus the register-file channel.
package debug_observer_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RDREQ  = 2'd1,
        S_RDWAIT = 2'd2,
        S_OUT    = 2'd3
    } state_t;

    localparam int CH_PC    = 0;
    localparam int CH_IR    = 1;
    localparam int CH_ALU_A = 2;
    localparam int CH_ALU_B = 3;
    localparam int CH_ALU_O = 4;
    localparam int CH_REG   = 5;

    // Value presented for a mode code with no channel behind it.
    localparam int OOR_FILL = 0;

endpackage

// File: rtl/debug_observer_snapshot.sv
// Snapshot bank: on a rising edge of freeze_i all direct channels are copied into shadows.
// frozen_o is freeze_i delayed by one cycle, so it rises together with the shadow capture.
module observer_snapshot
    import debug_observer_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int NUM_DIRECT = 5
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         freeze_i,
    input  logic [NUM_DIRECT*DATA_W-1:0] ch_data_i,
    output logic [NUM_DIRECT*DATA_W-1:0] shadow_o,
    output logic                         frozen_o
);

    logic freeze_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            freeze_q <= 1'b0;
            shadow_o <= '0;
        end else begin
            freeze_q <= freeze_i;
            if (freeze_i && !freeze_q) begin
                shadow_o <= ch_data_i;
            end
        end
    end

    assign frozen_o = freeze_q;

endmodule

// File: rtl/debug_observer.sv
// Handshaked debug observer: samples a direct channel or a register-file word and holds it on valid/ready.
// Optional snapshot of the direct channels is built when DEBUG_OBSERVER_SNAPSHOT_EN is defined.
module debug_observer
    import debug_observer_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int NUM_CH     = 6,
    parameter int REG_ADDR_W = 4,
    parameter int NUM_REGS   = 16,
    localparam int MODE_W    = $clog2(NUM_CH)
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         en_i,
    input  logic [MODE_W-1:0]            mode_i,
    input  logic                         scan_i,
    input  logic                         freeze_i,
    input  logic [(NUM_CH-1)*DATA_W-1:0] ch_data_i,
    input  logic [REG_ADDR_W-1:0]        reg_sel_i,
    input  logic [DATA_W-1:0]            reg_data_i,
    output logic [REG_ADDR_W-1:0]        reg_sel_o,
    output logic                         reg_read_o,
    output logic [DATA_W-1:0]            data_o,
    output logic [MODE_W-1:0]            tag_mode_o,
    output logic [REG_ADDR_W-1:0]        tag_reg_o,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic                         frozen_o,
    output logic [1:0]                   state_o
);

    // Handshake: valid_o is high only in S_OUT; data_o and both tags are stable there and the
    // sample is consumed on the first edge with valid_o && ready_i, after which valid_o drops.

    localparam int NUM_DIRECT = NUM_CH - 1;

    state_t                         state_q, state_d;
    logic [DATA_W-1:0]              data_q;
    logic [MODE_W-1:0]              mode_q;
    logic [REG_ADDR_W-1:0]          addr_q;
    logic [REG_ADDR_W-1:0]          scan_cnt_q;
    logic                           scan_txn_q;
    logic [NUM_DIRECT*DATA_W-1:0]   direct_src;
    logic [DATA_W-1:0]              direct_sel;
    logic                           frozen;

`ifdef DEBUG_OBSERVER_SNAPSHOT_EN
    logic [NUM_DIRECT*DATA_W-1:0] shadow;

    observer_snapshot #(
        .DATA_W     (DATA_W),
        .NUM_DIRECT (NUM_DIRECT)
    ) u_snapshot (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .freeze_i  (freeze_i),
        .ch_data_i (ch_data_i),
        .shadow_o  (shadow),
        .frozen_o  (frozen)
    );

    assign direct_src = frozen ? shadow : ch_data_i;
`else
    logic unused_freeze;

    assign unused_freeze = freeze_i;
    assign frozen        = 1'b0;
    assign direct_src    = ch_data_i;
`endif

    always_comb begin
        direct_sel = '0;
        for (int k = 0; k < NUM_DIRECT; k++) begin
            if (int'(mode_i) == k) begin
                direct_sel = direct_src[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (en_i) begin
                    state_d = (int'(mode_i) == NUM_CH - 1) ? S_RDREQ : S_OUT;
                end
            end
            S_RDREQ:  state_d = S_RDWAIT;
            S_RDWAIT: state_d = S_OUT;
            S_OUT: begin
                if (ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default:  state_d = S_IDLE;
        endcase
    end

    // Everything about a transaction is latched in S_IDLE so later input changes cannot leak in.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            data_q     <= '0;
            mode_q     <= '0;
            addr_q     <= '0;
            scan_cnt_q <= '0;
            scan_txn_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (en_i) begin
                        mode_q     <= mode_i;
                        scan_txn_q <= 1'b0;
                        if (int'(mode_i) < NUM_DIRECT) begin
                            data_q <= direct_sel;
                            addr_q <= '0;
                        end else if (int'(mode_i) == NUM_CH - 1) begin
                            addr_q     <= scan_i ? scan_cnt_q : reg_sel_i;
                            scan_txn_q <= scan_i;
                        end else begin
                            data_q <= DATA_W'(OOR_FILL);
                            addr_q <= '0;
                        end
                    end
                end
                S_RDWAIT: data_q <= reg_data_i;
                S_OUT: begin
                    if (ready_i && scan_txn_q) begin
                        scan_cnt_q <= (int'(scan_cnt_q) == NUM_REGS - 1) ? '0
                                                                          : scan_cnt_q + REG_ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign valid_o    = (state_q == S_OUT);
    assign reg_read_o = (state_q == S_RDREQ) || (state_q == S_RDWAIT);
    assign reg_sel_o  = addr_q;
    assign tag_reg_o  = addr_q;
    assign tag_mode_o = mode_q;
    assign data_o     = data_q;
    assign frozen_o   = frozen;
    assign state_o    = state_q;

endmodule

// File: tb/tb_debug_observer.sv
// Directed bench for debug_observer: driver tasks push expected samples, a negedge monitor pops them.
// Snapshot checks are compiled when DEBUG_OBSERVER_SNAPSHOT_EN is defined.
module tb_debug_observer;

    localparam int DATA_W     = 16;
    localparam int NUM_CH     = 6;
    localparam int REG_ADDR_W = 4;
    localparam int MODE_W     = 3;
    localparam int EXP_W      = MODE_W + REG_ADDR_W + DATA_W;

    logic                         clk;
    logic                         rst_n;
    logic                         en;
    logic [MODE_W-1:0]            mode;
    logic                         scan;
    logic                         freeze;
    logic [(NUM_CH-1)*DATA_W-1:0] ch_data;
    logic [REG_ADDR_W-1:0]        reg_sel;
    logic [DATA_W-1:0]            reg_data;
    logic [REG_ADDR_W-1:0]        reg_sel_o;
    logic                         reg_read_o;
    logic [DATA_W-1:0]            data_o;
    logic [MODE_W-1:0]            tag_mode_o;
    logic [REG_ADDR_W-1:0]        tag_reg_o;
    logic                         valid_o;
    logic                         ready;
    logic                         frozen_o;
    logic [1:0]                   state_o;

    logic [EXP_W-1:0] exp_q[$];
    int tests    = 0;
    int fails    = 0;
    int accepted = 0;

    debug_observer #(
        .DATA_W     (DATA_W),
        .NUM_CH     (NUM_CH),
        .REG_ADDR_W (REG_ADDR_W),
        .NUM_REGS   (16)
    ) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .en_i       (en),
        .mode_i     (mode),
        .scan_i     (scan),
        .freeze_i   (freeze),
        .ch_data_i  (ch_data),
        .reg_sel_i  (reg_sel),
        .reg_data_i (reg_data),
        .reg_sel_o  (reg_sel_o),
        .reg_read_o (reg_read_o),
        .data_o     (data_o),
        .tag_mode_o (tag_mode_o),
        .tag_reg_o  (tag_reg_o),
        .valid_o    (valid_o),
        .ready_i    (ready),
        .frozen_o   (frozen_o),
        .state_o    (state_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    // Register-file model, zero read latency.
    function automatic logic [DATA_W-1:0] reg_val(input logic [REG_ADDR_W-1:0] a);
        return (a == 4'h3) ? 16'h2000 : (16'hA000 + {12'h000, a});
    endfunction

    assign reg_data = reg_val(reg_sel_o);

    function automatic logic [EXP_W-1:0] pack(input logic [MODE_W-1:0] m,
                                              input logic [REG_ADDR_W-1:0] r,
                                              input logic [DATA_W-1:0] d);
        return {m, r, d};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst_n && valid_o && ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output: got %h expected none",
                         pack(tag_mode_o, tag_reg_o, data_o));
            end else begin
                check("output", 32'(pack(tag_mode_o, tag_reg_o, data_o)), 32'(exp_q.pop_front()));
            end
            accepted++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int k, input logic [DATA_W-1:0] v);
        ch_data[k*DATA_W +: DATA_W] = v;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    task automatic sample(input logic [MODE_W-1:0] m, input logic [REG_ADDR_W-1:0] r,
                          input logic [DATA_W-1:0] d);
        exp_q.push_back(pack(m, r, d));
        mode  = m;
        ready = 1'b1;
        en    = 1'b1;
        tick();
        en = 1'b0;
        drain();
    endtask

    task automatic check_reset_outputs();
        @(negedge clk);
        check("rst_data", 32'(data_o), 0);
        check("rst_tag_mode", 32'(tag_mode_o), 0);
        check("rst_tag_reg", 32'(tag_reg_o), 0);
        check("rst_valid", 32'(valid_o), 0);
        check("rst_reg_read", 32'(reg_read_o), 0);
        check("rst_reg_sel", 32'(reg_sel_o), 0);
        check("rst_frozen", 32'(frozen_o), 0);
        check("rst_state", 32'(state_o), 0);
    endtask

    // Hold en high with ready tied 1 until n samples are accepted; returns edges used.
    task automatic run_stream(input int n, output int cycles);
        int target;
        target = accepted + n;
        cycles = 0;
        en = 1'b1;
        while (accepted < target && cycles < 400) begin
            tick();
            cycles++;
        end
        en = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cyc;
        rst_n   = 1'b0;
        en      = 1'b0;
        mode    = '0;
        scan    = 1'b0;
        freeze  = 1'b0;
        ready   = 1'b0;
        reg_sel = '0;
        ch_data = '0;
        tick();
        tick();
        check_reset_outputs();
        tick();
        rst_n = 1'b1;
        tick();

        // Direct PC sample held against backpressure while the live channel moves.
        set_ch(0, 16'h2333);
        exp_q.push_back(pack(3'd0, 4'h0, 16'h2333));
        mode = 3'd0;
        en   = 1'b1;
        tick();
        en = 1'b0;
        @(negedge clk);
        check("direct_valid_latency", 32'(valid_o), 1);
        set_ch(0, 16'h1111);
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clk);
            check("hold_valid", 32'(valid_o), 1);
            check("hold_data", 32'(data_o), 32'h2333);
        end
        ready = 1'b1;
        drain();

        // Other direct channels with distinct patterns.
        set_ch(1, 16'hBEEF);
        set_ch(3, 16'h5A5A);
        set_ch(4, 16'h8001);
        sample(3'd1, 4'h0, 16'hBEEF);
        sample(3'd3, 4'h0, 16'h5A5A);
        sample(3'd4, 4'h0, 16'h8001);
        sample(3'd0, 4'h0, 16'h1111);

        // Manual register read; inputs changed after latching must not matter.
        exp_q.push_back(pack(3'd5, 4'h3, 16'h2000));
        mode    = 3'd5;
        reg_sel = 4'h3;
        ready   = 1'b1;
        en      = 1'b1;
        tick();
        en      = 1'b0;
        mode    = 3'd0;
        reg_sel = 4'h9;
        @(negedge clk);
        check("rd_c1_read", 32'(reg_read_o), 1);
        check("rd_c1_sel", 32'(reg_sel_o), 3);
        check("rd_c1_valid", 32'(valid_o), 0);
        tick();
        @(negedge clk);
        check("rd_c2_read", 32'(reg_read_o), 1);
        check("rd_c2_sel", 32'(reg_sel_o), 3);
        check("rd_c2_valid", 32'(valid_o), 0);
        tick();
        @(negedge clk);
        check("rd_c3_valid", 32'(valid_o), 1);
        check("rd_c3_read", 32'(reg_read_o), 0);
        drain();

        // Out-of-range mode codes.
        sample(3'd6, 4'h0, 16'h0000);
        sample(3'd7, 4'h0, 16'h0000);

        // Direct throughput: one sample per 2 cycles.
        set_ch(2, 16'h00A5);
        mode = 3'd2;
        ready = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back(pack(3'd2, 4'h0, 16'h00A5));
        run_stream(3, cyc);
        check("direct_throughput_cycles", 32'(cyc), 6);

        // Scan: 17 reads walk 0..15 then wrap to 0, one per 4 cycles.
        mode = 3'd5;
        scan = 1'b1;
        reg_sel = 4'hF;
        for (int i = 0; i < 17; i++) begin
            exp_q.push_back(pack(3'd5, 4'(i % 16), reg_val(4'(i % 16))));
        end
        run_stream(17, cyc);
        scan = 1'b0;
        check("scan_throughput_cycles", 32'(cyc), 68);
        check("scan_queue_empty", 32'(exp_q.size()), 0);

`ifdef DEBUG_OBSERVER_SNAPSHOT_EN
        set_ch(4, 16'h1100);
        tick();
        freeze = 1'b1;
        tick();
        set_ch(4, 16'hFFFF);
        @(negedge clk);
        check("snap_frozen", 32'(frozen_o), 1);
        tick();
        sample(3'd4, 4'h0, 16'h1100);
        freeze = 1'b0;
        tick();
        @(negedge clk);
        check("snap_released", 32'(frozen_o), 0);
        tick();
        sample(3'd4, 4'h0, 16'hFFFF);
`else
        freeze = 1'b1;
        set_ch(4, 16'h4242);
        tick();
        tick();
        @(negedge clk);
        check("nosnap_frozen", 32'(frozen_o), 0);
        tick();
        sample(3'd4, 4'h0, 16'h4242);
        freeze = 1'b0;
`endif

        // Reset while a sample waits in S_OUT under backpressure.
        set_ch(1, 16'h7777);
        mode  = 3'd1;
        ready = 1'b0;
        en    = 1'b1;
        tick();
        en = 1'b0;
        @(negedge clk);
        check("pre_reset_valid", 32'(valid_o), 1);
        rst_n = 1'b0;
        tick();
        check_reset_outputs();
        tick();
        rst_n = 1'b1;
        tick();
        sample(3'd1, 4'h0, 16'h7777);

        check("final_queue_empty", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
